// File: rtl/game_ctrl_m_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
// Cell i of a board vector occupies bits [2i+1:2i].
package game_ctrl_m_pkg;

  localparam int unsigned N_CELLS = 9;

  typedef logic                   FLAG_T;
  typedef logic [3:0]             INDEX_T;
  typedef logic [1:0]             STATE_T;
  typedef logic [1:0]             RESULT_T;
  typedef logic [2*N_CELLS-1:0]   BOARD_T;

  localparam FLAG_T TURN_PLAYER = 1'b0;
  localparam FLAG_T TURN_AI     = 1'b1;

  localparam STATE_T CELL_EMPTY = 2'd0;
  localparam STATE_T CELL_X     = 2'd1;
  localparam STATE_T CELL_O     = 2'd2;

  localparam RESULT_T RESULT_NONE = 2'd0;
  localparam RESULT_T RESULT_X    = 2'd1;
  localparam RESULT_T RESULT_O    = 2'd2;
  localparam RESULT_T RESULT_DRAW = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitMove,
    StCommit,
    StCheck,
    StDone
  } ctrl_state_e;

  // Out-of-range indices shift the board away and read as empty.
  function automatic STATE_T cell_at(input BOARD_T cells, input INDEX_T idx);
    BOARD_T shifted;
    shifted = cells >> {idx, 1'b0};
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_m_if.sv
// Signal bundle between the game sequencer, the move generators and the board store.
// slave is the sequencer's view; master is the surrounding environment's view.
interface game_ctrl_m_if;
  import game_ctrl_m_pkg::*;

  logic    start;
  logic    p_submit;
  INDEX_T  p_loc;
  STATE_T  p_val;
  logic    a_submit;
  INDEX_T  a_loc;
  STATE_T  a_val;
  BOARD_T  board_cells;

  FLAG_T   turn;
  logic    board_clr;
  logic    board_we;
  INDEX_T  board_loc;
  STATE_T  board_val;
  logic    move_err;
  logic [3:0] move_count;
  logic    game_over;
  RESULT_T result;

  modport master (
    output start, p_submit, p_loc, p_val, a_submit, a_loc, a_val, board_cells,
    input  turn, board_clr, board_we, board_loc, board_val, move_err, move_count,
           game_over, result
  );

  modport slave (
    input  start, p_submit, p_loc, p_val, a_submit, a_loc, a_val, board_cells,
    output turn, board_clr, board_we, board_loc, board_val, move_err, move_count,
           game_over, result
  );

endinterface

// File: rtl/game_ctrl_m_win_check.sv
// Combinational three-in-a-row detector over the eight board lines.
module win_check_m
  import game_ctrl_m_pkg::*;
(
  input  BOARD_T board_cells,
  output logic   x_win,
  output logic   o_win
);

  function automatic logic line_is(input BOARD_T cells, input int a, input int b, input int c,
                                   input STATE_T mark);
    return (cell_at(cells, INDEX_T'(a)) == mark) && (cell_at(cells, INDEX_T'(b)) == mark) &&
           (cell_at(cells, INDEX_T'(c)) == mark);
  endfunction

  function automatic logic any_line(input BOARD_T cells, input STATE_T mark);
    logic hit;
    hit = line_is(cells, 0, 4, 8, mark) | line_is(cells, 2, 4, 6, mark);
    for (int i = 0; i < 3; i++) begin
      hit = hit | line_is(cells, 3*i, 3*i + 1, 3*i + 2, mark) | line_is(cells, i, i + 3, i + 6, mark);
    end
    return hit;
  endfunction

  always_comb begin
    x_win = any_line(board_cells, CELL_X);
    o_win = any_line(board_cells, CELL_O);
  end

endmodule

// File: rtl/game_ctrl_m.sv
// Tic-tac-toe game sequencer: owns the turn, validates and commits moves to the board
// write port, and ends the game on a line, a full board or a side timing out.
module game_ctrl_m
  import game_ctrl_m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMER_W        = 8
) (
  input logic          clk,
  input logic          rst,
  game_ctrl_m_if.slave bus_io
);

  ctrl_state_e        state_q, state_d;
  FLAG_T              turn_q, turn_d;
  logic [3:0]         count_q, count_d;
  RESULT_T            result_q, result_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  INDEX_T             loc_q, loc_d;
  STATE_T             val_q, val_d;
  logic               err_q, err_d;
  logic               p_sub_q, a_sub_q;

  logic   x_win, o_win;
  logic   req, move_ok, timeout_hit;
  INDEX_T req_loc;
  STATE_T req_val;

  win_check_m u_win_check (
    .board_cells(bus_io.board_cells),
    .x_win      (x_win),
    .o_win      (o_win)
  );

  // Only the side holding the turn is looked at; the other side's edges are dropped.
  always_comb begin
    if (turn_q == TURN_AI) begin
      req     = bus_io.a_submit & ~a_sub_q;
      req_loc = bus_io.a_loc;
      req_val = bus_io.a_val;
    end else begin
      req     = bus_io.p_submit & ~p_sub_q;
      req_loc = bus_io.p_loc;
      req_val = bus_io.p_val;
    end
    move_ok = (req_loc < INDEX_T'(N_CELLS)) &&
              (cell_at(bus_io.board_cells, req_loc) == CELL_EMPTY) &&
              (req_val == ((turn_q == TURN_AI) ? CELL_O : CELL_X));
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_W'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    count_d  = count_q;
    result_d = result_q;
    timer_d  = timer_q;
    loc_d    = loc_q;
    val_d    = val_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          state_d  = StClear;
          turn_d   = TURN_PLAYER;
          count_d  = '0;
          result_d = RESULT_NONE;
          timer_d  = '0;
        end
      end
      StClear: state_d = StWaitMove;
      StWaitMove: begin
        timer_d = timer_q + 1'b1;
        err_d   = req & ~move_ok;
        // A valid move in the expiry cycle beats the forfeit.
        if (req && move_ok) begin
          loc_d   = req_loc;
          val_d   = req_val;
          state_d = StCommit;
        end else if (timeout_hit) begin
          result_d = (turn_q == TURN_PLAYER) ? RESULT_O : RESULT_X;
          state_d  = StDone;
        end
      end
      StCommit: begin
        count_d = count_q + 4'd1;
        state_d = StCheck;
      end
      StCheck: begin
        if (x_win) begin
          result_d = RESULT_X;
          state_d  = StDone;
        end else if (o_win) begin
          result_d = RESULT_O;
          state_d  = StDone;
        end else if (count_q == 4'd9) begin
          result_d = RESULT_DRAW;
          state_d  = StDone;
        end else begin
          turn_d  = ~turn_q;
          timer_d = '0;
          state_d = StWaitMove;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      turn_q   <= TURN_PLAYER;
      count_q  <= '0;
      result_q <= RESULT_NONE;
      timer_q  <= '0;
      loc_q    <= '0;
      val_q    <= CELL_EMPTY;
      err_q    <= 1'b0;
      p_sub_q  <= 1'b0;
      a_sub_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      result_q <= result_d;
      timer_q  <= timer_d;
      loc_q    <= loc_d;
      val_q    <= val_d;
      err_q    <= err_d;
      p_sub_q  <= bus_io.p_submit;
      a_sub_q  <= bus_io.a_submit;
    end
  end

  assign bus_io.turn       = turn_q;
  assign bus_io.board_clr  = (state_q == StClear);
  assign bus_io.board_we   = (state_q == StCommit);
  assign bus_io.board_loc  = loc_q;
  assign bus_io.board_val  = val_q;
  assign bus_io.move_err   = err_q;
  assign bus_io.move_count = count_q;
  assign bus_io.game_over  = (state_q == StDone);
  assign bus_io.result     = result_q;

endmodule

// File: tb/tb_game_ctrl_m.sv
// Bench for game_ctrl_m: directed games plus random games against a rules-level model
// of the board, turn order and game outcome.
module tb_game_ctrl_m;
  import game_ctrl_m_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_m_if bus ();

  logic [17:0] board = '0;
  int we_cnt = 0;
  int tests  = 0;
  int fails  = 0;

  int mb[9];
  int mcount;
  int mturn;
  bit mdone;

  assign bus.board_cells = board;

  game_ctrl_m #(
    .TIMEOUT_CYCLES(10),
    .TIMER_W       (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  // Board storage stand-in.
  always @(posedge clk) begin
    if (bus.board_clr) board <= '0;
    else if (bus.board_we) board[2*int'(bus.board_loc) +: 2] <= bus.board_val;
  end

  always @(posedge clk) if (bus.board_we) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
    foreach (lines[l]) begin
      if (mb[lines[l][0]] != 0 && mb[lines[l][0]] == mb[lines[l][1]] &&
          mb[lines[l][1]] == mb[lines[l][2]]) return mb[lines[l][0]];
    end
    return 0;
  endfunction

  task automatic drive(input int side, input bit s, input int loc, input int val);
    if (side != 0) begin
      bus.a_submit = s; bus.a_loc = 4'(loc); bus.a_val = 2'(val);
    end else begin
      bus.p_submit = s; bus.p_loc = 4'(loc); bus.p_val = 2'(val);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_turn", bus.turn, 0);
    check("rst_clr", bus.board_clr, 0);
    check("rst_we", bus.board_we, 0);
    check("rst_loc", bus.board_loc, 0);
    check("rst_val", bus.board_val, 0);
    check("rst_err", bus.move_err, 0);
    check("rst_count", bus.move_count, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_result", bus.result, 0);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("clr_pulse", bus.board_clr, 1);
    check("clr_no_we", bus.board_we, 0);
    check("clr_count", bus.move_count, 0);
    check("clr_result", bus.result, 0);
    check("clr_turn", bus.turn, 0);
    @(negedge clk);
    check("clr_one_cycle", bus.board_clr, 0);
    foreach (mb[i]) mb[i] = 0;
    mcount = 0;
    mturn  = 0;
    mdone  = 1'b0;
  endtask

  // Called on a negedge with the DUT waiting for a move from the side holding the turn.
  task automatic do_move(input int side, input int loc, input int val, input bit hold);
    bit ok;
    int w;
    ok = 1'b0;
    if (side == mturn && loc >= 0 && loc < 9)
      ok = (mb[loc] == 0) && (val == ((side != 0) ? 2 : 1));
    drive(side, 1'b1, loc, val);
    @(negedge clk);
    check("we", bus.board_we, ok);
    check("err", bus.move_err, !ok);
    check("we_clr_excl", bus.board_clr, 0);
    if (ok) begin
      check("wr_loc", bus.board_loc, loc);
      check("wr_val", bus.board_val, val);
      check("not_over", bus.game_over, 0);
    end
    if (!hold) drive(side, 1'b0, loc, val);
    @(negedge clk);
    if (!ok) begin
      check("err_one_cycle", bus.move_err, 0);
      check("turn_kept", bus.turn, mturn);
      return;
    end
    mb[loc] = val;
    mcount++;
    check("count", bus.move_count, mcount);
    @(negedge clk);
    w = model_winner();
    if (w != 0 || mcount == 9) begin
      mdone = 1'b1;
      check("over", bus.game_over, 1);
      check("result", bus.result, (w != 0) ? w : 3);
      check("turn_held", bus.turn, mturn);
    end else begin
      mturn ^= 1;
      check("over_low", bus.game_over, 0);
      check("turn_flip", bus.turn, mturn);
    end
  endtask

  initial begin
    int k, base, loc, val, attempts, n_empty, prev;
    int empties[9];
    bus.start = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    foreach (mb[i]) mb[i] = 0;
    mcount = 0; mturn = 0; mdone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Player wins on the top row.
    base = we_cnt;
    start_game();
    do_move(0, 0, 1, 1'b0);
    do_move(1, 3, 2, 1'b0);
    do_move(0, 1, 1, 1'b0);
    do_move(1, 4, 2, 1'b0);
    do_move(0, 2, 1, 1'b0);
    check("win_we_count", we_cnt - base, 5);
    check("win_count", bus.move_count, 5);
    check("win_result", bus.result, 1);

    // Draw game with illegal moves, a wrong-side pulse and a held submit.
    start_game();
    do_move(0, 0, 1, 1'b0);
    do_move(1, 1, 2, 1'b0);
    base = we_cnt;
    drive(1, 1'b1, 3, 2);
    @(negedge clk);
    check("wrong_side_we", bus.board_we, 0);
    check("wrong_side_err", bus.move_err, 0);
    drive(1, 1'b0, 3, 2);
    @(negedge clk);
    check("wrong_side_err2", bus.move_err, 0);
    check("wrong_side_no_write", we_cnt - base, 0);
    do_move(0, 2, 1, 1'b0);
    do_move(1, 4, 2, 1'b0);
    base = we_cnt;
    do_move(0, 4, 1, 1'b0);
    do_move(0, 9, 1, 1'b0);
    do_move(0, 3, 2, 1'b0);
    check("illegal_no_write", we_cnt - base, 0);
    check("illegal_turn", bus.turn, 0);
    do_move(0, 3, 1, 1'b0);
    do_move(1, 5, 2, 1'b0);
    base = we_cnt;
    do_move(0, 7, 1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 7, 1);
    @(negedge clk);
    check("held_once", we_cnt - base, 1);
    do_move(1, 6, 2, 1'b0);
    do_move(0, 8, 1, 1'b0);
    check("draw_result", bus.result, 3);
    check("draw_count", bus.move_count, 9);

    // AI stalls: forfeit exactly eleven cycles after the turn reaches it.
    start_game();
    do_move(0, 0, 1, 1'b0);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.game_over) begin
        k = i;
        break;
      end
    end
    check("timeout_cycles", k, 11);
    check("timeout_result", bus.result, 1);
    check("timeout_turn", bus.turn, 1);
    check("timeout_count", bus.move_count, 1);

    // AI move landing on the expiry cycle is committed instead of forfeiting.
    start_game();
    do_move(0, 0, 1, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    do_move(1, 4, 2, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_ignored", bus.board_clr, 0);
    @(negedge clk);

    // Reset in the middle of a commit.
    drive(0, 1'b1, 8, 1);
    @(negedge clk);
    check("pre_rst_we", bus.board_we, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    drive(0, 1'b0, 8, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_over", bus.game_over, 0);
    check("post_rst_count", bus.move_count, 0);
    start_game();

    // Random games, each move checked against the rules model.
    for (int g = 0; g < 4; g++) begin
      if (g != 0) start_game();
      attempts = 0;
      while (!mdone) begin
        if (attempts < 2 && $urandom_range(0, 3) == 0) begin
          loc = int'($urandom_range(0, 15));
          val = int'($urandom_range(0, 3));
          attempts++;
        end else begin
          n_empty = 0;
          for (int c = 0; c < 9; c++) if (mb[c] == 0) begin
            empties[n_empty] = c;
            n_empty++;
          end
          loc = empties[$urandom_range(0, n_empty - 1)];
          val = (mturn != 0) ? 2 : 1;
        end
        prev = mcount;
        do_move(mturn, loc, val, 1'b0);
        if (mcount != prev) attempts = 0;
      end
      check("rand_over", bus.game_over, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl_m.md
Name: game_ctrl_m

Overview:
Synchronous game sequencer for the tic-tac-toe board. It owns the turn flag and arbitrates the single board write port between the player and AI move generators. It validates each submitted move, commits it, then checks for a win or draw after every move. It sits between the two move generators and the board storage module.

Parameters:
TIMEOUT_CYCLES, 255, cycles a side may wait in WAIT_MOVE before forfeiting; 0 disables timeout
TIMER_W, 8, timeout counter width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a new game; honoured only in IDLE or DONE
p_submit  input  1  player move request (level, rising-edge detected)
p_loc  input  INDEX_T  player target cell, 0..8
p_val  input  STATE_T  player mark
a_submit  input  1  AI move request (level, rising-edge detected)
a_loc  input  INDEX_T  AI target cell
a_val  input  STATE_T  AI mark
board_cells  input  18  current board, cell i at [2i+1:2i], STATE_T encoding
turn  output  FLAG_T  TURN_PLAYER (0) or TURN_AI (1)
board_clr  output  1  one-cycle board clear pulse
board_we  output  1  one-cycle board write strobe
board_loc  output  INDEX_T  write address
board_val  output  STATE_T  write data
move_err  output  1  one-cycle pulse on a rejected move
move_count  output  4  committed moves this game, 0..9
game_over  output  1  high in DONE
result  output  2  0 none, 1 X/player win, 2 O/AI win, 3 draw

Behaviour:
- Reset (async, rst=1): state=IDLE, turn=TURN_PLAYER, all other outputs 0, timer 0, submit edge registers 0.
- Submit detect: submit_q registered per side; request = submit & ~submit_q. Only the side matching turn is evaluated; the other side's edges are ignored silently.
- IDLE: start -> CLEAR.
- CLEAR: board_clr=1 for exactly 1 cycle; move_count=0, result=0, turn=TURN_PLAYER, timer=0 -> WAIT_MOVE.
- WAIT_MOVE: timer increments each cycle. On request, the move is valid iff loc<9, the board_cells cell equals CELL_EMPTY, and val = CELL_X (player) / CELL_O (AI).
  - Valid: latch loc/val into board_loc/board_val -> COMMIT.
  - Invalid: move_err=1 for 1 cycle, stay; the timer is not cleared.
- COMMIT: board_we=1 for 1 cycle, move_count+1 -> CHECK. The board updates on this edge, so CHECK sees the new contents.
- CHECK: evaluate board_cells through win_check_m.
  - Line of X -> result=1, DONE.
  - Line of O -> result=2, DONE.
  - Else if move_count==9 -> result=3, DONE.
  - Else toggle turn, timer=0 -> WAIT_MOVE.
- Timeout: in WAIT_MOVE, timer==TIMEOUT_CYCLES with no valid request that cycle -> forfeit. result = the opposing side's code (player stalls -> 2; AI stalls -> 1), DONE. A valid request in the expiry cycle wins over the timeout.
- DONE: game_over=1; result, move_count and turn are held. start -> CLEAR.
- start outside IDLE/DONE: ignored.
- Move latency: request edge -> board_we 1 cycle later -> turn flips 2 cycles after board_we, when no win.
- board_we and board_clr are never asserted together.
- rst mid-game: immediate return to IDLE; board contents are not cleared until the next start.

Decomposition:
- Shared defines file: FLAG_T, INDEX_T, STATE_T, TURN_PLAYER/TURN_AI, CELL_EMPTY/X/O, RESULT_NONE/X/O/DRAW, N_CELLS=9.
- Sub-module win_check_m (combinational): input board_cells, outputs x_win, o_win.
  - Covers 8 lines: rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.

Test Plan:
- Player wins: start, then moves P0,A3,P1,A4,P2 -> board_we five times, result=1, game_over=1, move_count=5, turn held TURN_PLAYER.
- Draw: nine valid alternating moves with no line, e.g. X:0,2,3,7,8 and O:1,4,5,6 -> result=3, move_count=9.
- Illegal move: player submits loc=4 after the AI took 4, then loc=9, then val=CELL_O -> three move_err pulses, no board_we, turn stays TURN_PLAYER; a valid move is then accepted.
- Wrong side: a_submit pulse during the player's turn -> no board_we, no move_err. A held p_submit commits only once.
- Timeout: TIMEOUT_CYCLES=10, AI never submits -> DONE with result=1 exactly 11 cycles after turn flips to AI.
  - Same test with a valid AI submit landing on the expiry cycle -> move committed, no forfeit.
- Reset mid-game: rst asserted during COMMIT -> all outputs 0 asynchronously. A subsequent start pulses board_clr, and move_count restarts at 0.
